// File: rtl/rv_mem_pkg.sv
// Shared types and helpers for the instruction memory controller.
// Holds the NOP constant, the controller state encoding and the fetch fault check.
package rv_mem_pkg;

  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  typedef enum logic {
    INIT,
    READY
  } ctrl_state_t;

  typedef struct packed {
    logic misaligned;
    logic out_of_range;
  } fetch_fault_t;

  // Address is zero-extended to 64 bits by the caller so one helper serves any ADDR_W.
  function automatic fetch_fault_t check_fetch(input logic [63:0] addr, input int depth);
    fetch_fault_t f;
    f.misaligned   = (addr[1:0] != 2'b00);
    f.out_of_range = ((addr >> 2) >= 64'(depth));
    return f;
  endfunction

endpackage

// File: rtl/instr_mem_ctrl_if.sv
// Fetch, response and program-port signals between the fetch stage and the instruction memory.
// The slave modport is the memory side, the master modport the fetch/decode side.
interface instr_mem_ctrl_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32,
  parameter int IDX_W  = 6
);

  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_gnt;
  logic              rsp_valid;
  logic [XLEN-1:0]   rsp_instr;
  logic              rsp_fault;
  logic              rsp_stall;
  logic              prog_we;
  logic [IDX_W-1:0]  prog_idx;
  logic [XLEN-1:0]   prog_wdata;
  logic              init_done;

  modport master (
    output fetch_req, fetch_addr, rsp_stall, prog_we, prog_idx, prog_wdata,
    input  fetch_gnt, rsp_valid, rsp_instr, rsp_fault, init_done
  );

  modport slave (
    input  fetch_req, fetch_addr, rsp_stall, prog_we, prog_idx, prog_wdata,
    output fetch_gnt, rsp_valid, rsp_instr, rsp_fault, init_done
  );

endinterface

// File: rtl/instr_mem_ctrl_imem_ram.sv
// 1R1W synchronous RAM, 1-cycle registered read; a same-edge write to the read word returns old data.
// The read register only updates when re is high, so the last read value is held otherwise.
module imem_ram #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 64,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [XLEN-1:0]  wdata,
  input  logic             re,
  input  logic [IDX_W-1:0] raddr,
  output logic [XLEN-1:0]  rdata
);

  logic [XLEN-1:0] mem [DEPTH];
  logic [XLEN-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/instr_mem_ctrl.sv
// Instruction memory controller: post-reset init sweep, 1-cycle fetch with fault reporting, program port.
// Latency 1 cycle; a stalled response is held and blocks new grants, program writes are never blocked.
module instr_mem_ctrl
  import rv_mem_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter int              DEPTH      = 64,
  parameter int              ADDR_W     = 32,
  parameter logic [XLEN-1:0] INIT_WORD  = XLEN'(RV_NOP),
  parameter logic [XLEN-1:0] FAULT_WORD = XLEN'(RV_NOP)
) (
  input logic             clk,
  input logic             rst,
  instr_mem_ctrl_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);

  ctrl_state_t      state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             init_done_q, init_done_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_fault_q, rsp_fault_d;
  logic             rsp_from_ram_q, rsp_from_ram_d;
  logic [XLEN-1:0]  rsp_hold_q, rsp_hold_d;

  fetch_fault_t     fault;
  logic             fault_any;
  logic             gnt;
  logic             ram_we;
  logic             ram_re;
  logic [IDX_W-1:0] ram_waddr;
  logic [IDX_W-1:0] ram_raddr;
  logic [XLEN-1:0]  ram_wdata;
  logic [XLEN-1:0]  ram_rdata;

  assign fault     = check_fetch(64'(bus.fetch_addr), DEPTH);
  assign fault_any = fault.misaligned | fault.out_of_range;
  assign gnt       = (state_q == READY) && bus.fetch_req && !(rsp_valid_q && bus.rsp_stall);

  // The sweep owns the write port in INIT, so program writes there are simply dropped.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = cnt_q;
    ram_wdata = INIT_WORD;
    if (!rst) begin
      if (state_q == INIT) begin
        ram_we = 1'b1;
      end else if (bus.prog_we) begin
        ram_we    = 1'b1;
        ram_waddr = bus.prog_idx;
        ram_wdata = bus.prog_wdata;
      end
    end
  end

  assign ram_re    = gnt && !fault_any;
  assign ram_raddr = bus.fetch_addr[IDX_W+1:2];

  imem_ram #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    init_done_d    = init_done_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_fault_d    = rsp_fault_q;
    rsp_from_ram_d = rsp_from_ram_q;
    rsp_hold_d     = rsp_hold_q;

    if (state_q == INIT) begin
      cnt_d = cnt_q + IDX_W'(1);
      if (cnt_q == IDX_W'(DEPTH - 1)) begin
        state_d     = READY;
        init_done_d = 1'b1;
      end
    end

    // Faulting fetches never touch the RAM; the fault word is parked in the hold register.
    if (gnt) begin
      rsp_valid_d    = 1'b1;
      rsp_fault_d    = fault_any;
      rsp_from_ram_d = !fault_any;
      if (fault_any) begin
        rsp_hold_d = FAULT_WORD;
      end
    end else if (!(rsp_valid_q && bus.rsp_stall)) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= INIT;
      cnt_q          <= '0;
      init_done_q    <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_fault_q    <= 1'b0;
      rsp_from_ram_q <= 1'b0;
      rsp_hold_q     <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      init_done_q    <= init_done_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_fault_q    <= rsp_fault_d;
      rsp_from_ram_q <= rsp_from_ram_d;
      rsp_hold_q     <= rsp_hold_d;
    end
  end

  assign bus.fetch_gnt = gnt;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_fault = rsp_fault_q;
  assign bus.rsp_instr = rsp_from_ram_q ? ram_rdata : rsp_hold_q;
  assign bus.init_done = init_done_q;

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Bench for instr_mem_ctrl: directed scenarios plus random traffic against a word-array reference model.
module tb_instr_mem_ctrl;
  import rv_mem_pkg::*;

  localparam int XLEN   = 32;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 32;
  localparam int IDX_W  = $clog2(DEPTH);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_mem_ctrl_if #(.XLEN(XLEN), .ADDR_W(ADDR_W), .IDX_W(IDX_W)) bus ();

  instr_mem_ctrl #(
    .XLEN   (XLEN),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] ref_mem [DEPTH];
  int          ref_sweep;
  bit          ref_ready;
  bit          ref_vld;
  logic [31:0] ref_instr;
  bit          ref_fault;
  int          n_chk = 0;
  int          n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: check the grant, advance the model across the edge, then check the response.
  task automatic cycle();
    bit          g;
    bit          flt;
    logic [31:0] a;
    #1;
    a = bus.fetch_addr;
    g = ref_ready && bus.fetch_req && !(ref_vld && bus.rsp_stall);
    if (!rst) chk("gnt", bus.fetch_gnt, g);
    if (rst) begin
      ref_ready = 0;
      ref_sweep = 0;
      ref_vld   = 0;
      ref_instr = 0;
      ref_fault = 0;
      foreach (ref_mem[i]) ref_mem[i] = RV_NOP;
    end else begin
      if (g) begin
        flt       = (a % 4 != 0) || ((a / 4) >= DEPTH);
        ref_vld   = 1;
        ref_fault = flt;
        if (flt) ref_instr = RV_NOP;
        else     ref_instr = ref_mem[a / 4];
      end else if (!(ref_vld && bus.rsp_stall)) begin
        ref_vld = 0;
      end
      if (ref_ready) begin
        if (bus.prog_we) ref_mem[bus.prog_idx] = bus.prog_wdata;
      end else begin
        ref_sweep++;
        if (ref_sweep == DEPTH) ref_ready = 1;
      end
    end
    @(posedge clk);
    #1;
    chk("valid", bus.rsp_valid, ref_vld);
    chk("instr", bus.rsp_instr, ref_instr);
    chk("fault", bus.rsp_fault, ref_fault);
    chk("init_done", bus.init_done, ref_ready);
  endtask

  task automatic drive(input bit req, input logic [31:0] addr, input bit stall,
                       input bit we, input int idx, input logic [31:0] wd);
    bus.fetch_req  = req;
    bus.fetch_addr = addr;
    bus.rsp_stall  = stall;
    bus.prog_we    = we;
    bus.prog_idx   = IDX_W'(idx);
    bus.prog_wdata = wd;
    cycle();
  endtask

  // Releases reset and counts cycles until init_done, fetching and optionally writing idx 2 meanwhile.
  task automatic release_and_count(input bit with_prog, output int n);
    rst = 0;
    n   = -1;
    for (int k = 1; k <= 200; k++) begin
      drive(1, 32'h0, 0, with_prog && (k == 10), 2, 32'hDEAD_BEEF);
      if (bus.init_done === 1'b1) begin
        n = k;
        break;
      end
    end
  endtask

  initial begin
    int          n;
    logic [31:0] a;
    rst = 1;
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("rst_valid", bus.rsp_valid, 0);
    chk("rst_instr", bus.rsp_instr, 0);
    chk("rst_fault", bus.rsp_fault, 0);
    chk("rst_init_done", bus.init_done, 0);

    release_and_count(0, n);
    chk("sweep_len", n, DEPTH);

    drive(1, 32'h00, 0, 0, 0, 0);
    chk("word0_nop", bus.rsp_instr, RV_NOP);
    chk("word0_fault", bus.rsp_fault, 0);

    drive(0, 0, 0, 1, 3, 32'hFFC4_A303);
    drive(1, 32'h0C, 0, 0, 0, 0);
    chk("prog_fetch_vld", bus.rsp_valid, 1);
    chk("prog_fetch", bus.rsp_instr, 32'hFFC4_A303);

    drive(1, 32'h0E, 0, 0, 0, 0);
    chk("misalign_fault", bus.rsp_fault, 1);
    chk("misalign_instr", bus.rsp_instr, RV_NOP);
    drive(1, 32'h100, 0, 0, 0, 0);
    chk("range_fault", bus.rsp_fault, 1);
    drive(1, 32'hFC, 0, 0, 0, 0);
    chk("last_word_ok", bus.rsp_fault, 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("idle_drop", bus.rsp_valid, 0);

    // Stall hold on the word-1 response.
    drive(0, 0, 0, 1, 1, 32'hAAAA_0001);
    drive(0, 0, 0, 1, 2, 32'hBBBB_0002);
    drive(1, 32'h00, 0, 0, 0, 0);
    drive(1, 32'h04, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h08, 1, 0, 0, 0);
      chk("stall_hold", bus.rsp_instr, 32'hAAAA_0001);
    end
    drive(1, 32'h08, 0, 0, 0, 0);
    chk("after_stall", bus.rsp_instr, 32'hBBBB_0002);

    // Read-before-write collision on word 5.
    drive(0, 0, 0, 1, 5, 32'h1111_1111);
    drive(1, 32'h14, 0, 1, 5, 32'h2222_2222);
    chk("collide_old", bus.rsp_instr, 32'h1111_1111);
    drive(1, 32'h14, 0, 0, 0, 0);
    chk("collide_new", bus.rsp_instr, 32'h2222_2222);

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        7:       a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
        8:       a = 32'($urandom_range(DEPTH, 1023)) << 2;
        9:       a = $urandom;
        default: a = 32'($urandom_range(0, DEPTH - 1)) << 2;
      endcase
      drive($urandom_range(0, 3) != 0, a, $urandom_range(0, 2) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, DEPTH - 1), $urandom);
    end

    // Reset mid-sweep, with a program write attempted during INIT.
    rst = 1;
    drive(1, 32'h04, 0, 0, 0, 0);
    drive(1, 32'h04, 0, 0, 0, 0);
    rst = 0;
    for (int k = 0; k < 30; k++) drive(1, 32'h0, 0, k == 10, 2, 32'hCAFE_F00D);
    rst = 1;
    drive(0, 0, 0, 0, 0, 0);
    chk("midsweep_rst_vld", bus.rsp_valid, 0);
    release_and_count(1, n);
    chk("resweep_len", n, DEPTH);
    drive(1, 32'h08, 0, 0, 0, 0);
    chk("init_write_dropped", bus.rsp_instr, RV_NOP);
    drive(0, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_mem_ctrl.md
Name: instr_mem_ctrl

Overview:
- Parametrised instruction memory for the single-cycle/pipelined RISC-V core; successor to the fixed 16-word combinational instruction store.
- Adds a synchronous 1-cycle read with a request/grant and response/stall handshake, plus a post-reset initialisation sweep.
- Adds a runtime programming (load) port and alignment/range fault reporting.
- Sits between the PC/fetch stage and the decode stage.

Parameters:
- XLEN, 32, instruction word width in bits.
- DEPTH, 64, number of instruction words; power of two, at least 2.
- ADDR_W, 32, byte-address width of fetch_addr.
- INIT_WORD, 32'h00000013, value written to every word during the init sweep (RV32I NOP).
- FAULT_WORD, 32'h00000013, instruction returned on a faulting fetch.
- Local parameter IDX_W = clog2(DEPTH).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- fetch_req  in  1  fetch request.
- fetch_addr  in  ADDR_W  fetch byte address (PC).
- fetch_gnt  out  1  request accepted this cycle.
- rsp_valid  out  1  response holds a valid instruction.
- rsp_instr  out  XLEN  fetched instruction.
- rsp_fault  out  1  response is due to a misaligned or out-of-range address.
- rsp_stall  in  1  consumer cannot take the response; hold it.
- prog_we  in  1  program-port write strobe.
- prog_idx  in  IDX_W  program-port word index.
- prog_wdata  in  XLEN  program-port data.
- init_done  out  1  init sweep complete; block is usable.

Behaviour:
- Reset: rst=1 on a clock edge forces state INIT and the sweep counter to 0.
  - Reset values: rsp_valid=0, rsp_instr=0, rsp_fault=0, init_done=0, fetch_gnt=0.
  - Reset asserted mid-sweep or mid-fetch restarts the sweep from index 0. Any pending response is dropped.
- State machine, two states:
  - INIT: writes INIT_WORD to mem[cnt] and increments cnt each cycle. After writing index DEPTH-1, moves to READY; init_done rises on the first READY cycle. A full sweep takes exactly DEPTH cycles after rst deasserts.
  - READY: normal operation; there is no path back to INIT except reset.
- In INIT, fetch_gnt=0 and prog_we is ignored. Writes during the sweep are dropped, not queued.
- fetch_gnt is combinational: (state==READY) && fetch_req && !(rsp_valid && rsp_stall).
- Fetch latency is 1 cycle. A grant at edge N produces rsp_valid=1 after edge N, with data from mem[fetch_addr[IDX_W+1:2]].
- Fault checks are evaluated at grant time:
  - misaligned: fetch_addr[1:0]!=0;
  - out of range: fetch_addr[ADDR_W-1:2] >= DEPTH.
  - On a fault: rsp_instr=FAULT_WORD and rsp_fault=1; no memory read is used.
  - Misalignment takes precedence but yields the same outputs.
- Stall: while rsp_valid && rsp_stall, rsp_instr, rsp_fault and rsp_valid are held unchanged and no new grant is issued.
- Without a grant and without a stall, rsp_valid drops to 0. rsp_instr keeps its last value.
- Back-to-back grants with no stall give one response per cycle (full throughput).
- Program port, READY only: prog_we writes prog_wdata to mem[prog_idx] at the edge.
  - A write and a grant in the same cycle to the same word return the OLD data (read-before-write). The new data is visible from the next grant.
  - prog_we is independent of the stall; writes are never blocked in READY.
- Memory is inferred as single-write, single-read synchronous RAM. There is no initial-block preload; contents come from the sweep or the program port.

Decomposition:
- Shared package rv_mem_pkg holds:
  - the NOP constant 32'h00000013, used for INIT_WORD and FAULT_WORD defaults;
  - the two-state enum {INIT, READY};
  - the fault-check helper function (alignment and range).
- One sub-module is natural: imem_ram, a parametrised 1R1W synchronous RAM (XLEN x DEPTH, read-before-write). The controller FSM, fault logic and response register stay in instr_mem_ctrl.

Test Plan:
- Reset then init: rst high 2 cycles, release, with DEPTH=64.
  - Required: init_done=0 for 64 cycles, then 1.
  - Required: fetch 0x00 then returns 0x00000013 with rsp_fault=0.
- Program and fetch: prog_we with idx 3 and data 0xFFC4A303, then fetch 0x0C.
  - Required: one cycle after the grant, rsp_valid=1 and rsp_instr=0xFFC4A303.
- Faults:
  - fetch 0x0E gives rsp_fault=1 and rsp_instr=0x00000013.
  - fetch 0x100 (DEPTH=64) gives rsp_fault=1.
  - fetch 0xFC gives rsp_fault=0.
- Stall hold: stream fetches 0x00, 0x04, 0x08 while asserting rsp_stall for 3 cycles on the 0x04 response.
  - Required: rsp_instr stays at word 1 and fetch_gnt=0 during the stall.
  - Required: word 2 arrives on the cycle after rsp_stall drops.
- Collision: word 5 holds 0x11111111; prog_we writes 0x22222222 to idx 5 in the same cycle as a fetch of 0x14.
  - Required: the response is 0x11111111 and the next fetch of 0x14 returns 0x22222222.
- Reset mid-sweep and write during INIT: assert rst at sweep cycle 30.
  - Required: init_done stays 0 for a further 64 cycles after release.
  - Required: a prog_we to idx 2 issued during INIT is dropped, so fetch 0x08 returns 0x00000013.
